seri2para_frame_packer: RTL and testbench

- Downstream of the flash parallel-to-serial stage.
- Consumes the 1-bit-per-clock binary pixel stream of a 640x480 frame and packs it MSB-first into 16-bit words.
- Buffers the words in a small FIFO and writes them to SRAM through a WE/ACK handshake.
- Reports line completion, frame completion and overflow; the upstream stream has no backpressure, so the FIFO absorbs SRAM latency.

---
 rtl/seri2para_pkg.sv | 19 +
 rtl/seri2para_frame_packer_word_fifo.sv | 52 +++++
 rtl/seri2para_frame_packer.sv | 135 +++++++++++++
 tb/tb_seri2para_frame_packer.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/seri2para_pkg.sv
// Shared FSM state, default frame geometry and FIFO entry layout for the
// serial-to-parallel frame packer.
package seri2para_pkg;

    typedef enum logic [1:0] {IDLE, CAPTURE, DRAIN, DONE} state_t;

    localparam int unsigned H_PIXELS_DEF    = 640;
    localparam int unsigned V_LINES_DEF     = 480;
    localparam int unsigned WORD_W_DEF      = 16;
    localparam int unsigned ADDR_W_DEF      = 20;
    localparam int unsigned WORDS_PER_LINE  = H_PIXELS_DEF / WORD_W_DEF;
    localparam int unsigned WORDS_PER_FRAME = WORDS_PER_LINE * V_LINES_DEF;

    typedef struct packed {
        logic [ADDR_W_DEF-1:0] index;
        logic [WORD_W_DEF-1:0] data;
    } fifoEntry_t;

endpackage

// File: rtl/seri2para_frame_packer_word_fifo.sv
// Register-based FIFO; the head entry is presented straight from storage so a
// pushed word is visible on the read side one cycle later.
module word_fifo #(
    parameter int unsigned WIDTH = 36,
    parameter int unsigned DEPTH = 4
) (
    input  logic                   iCLK,
    input  logic                   iRST_n,
    input  logic                   push,
    input  logic [WIDTH-1:0]       pushData,
    input  logic                   pop,
    output logic [WIDTH-1:0]       headData,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rdPtr;
    logic [PTR_W-1:0] wrPtr;
    logic             doPush;
    logic             doPop;

    assign empty    = (count == '0);
    assign full     = (count == (PTR_W + 1)'(DEPTH));
    assign doPop    = pop && !empty;
    // A push into a full FIFO only lands if the head leaves in the same cycle.
    assign doPush   = push && (!full || doPop);
    assign headData = mem[rdPtr];

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) begin
                mem[wrPtr] <= pushData;
                wrPtr      <= wrPtr + 1'b1;
            end
            if (doPop) begin
                rdPtr <= rdPtr + 1'b1;
            end
            count <= count + (PTR_W + 1)'(doPush) - (PTR_W + 1)'(doPop);
        end
    end

endmodule

// File: rtl/seri2para_frame_packer.sv
// Packs a 1-bit-per-clock pixel stream MSB-first into words and writes them to
// SRAM over a WE/ACK handshake, with a small FIFO absorbing SRAM latency.
module seri2para_frame_packer
    import seri2para_pkg::*;
#(
    parameter int unsigned       H_PIXELS   = H_PIXELS_DEF,
    parameter int unsigned       V_LINES    = V_LINES_DEF,
    parameter int unsigned       WORD_W     = WORD_W_DEF,
    parameter int unsigned       ADDR_W     = ADDR_W_DEF,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = '0,
    parameter int unsigned       FIFO_DEPTH = 4
) (
    input  logic              iCLK,
    input  logic              iRST_n,
    input  logic              iSTART,
    input  logic              iPIXEL,
    input  logic              iPIXEL_VALID,
    output logic              oSRAM_WE,
    output logic [ADDR_W-1:0] oSRAM_ADDR,
    output logic [WORD_W-1:0] oSRAM_DATA,
    input  logic              iSRAM_ACK,
    output logic              oLINE_DONE,
    output logic              oFinished,
    output logic              oOVERFLOW,
    output logic              oBUSY
);
    localparam int unsigned COL_W = $clog2(H_PIXELS);
    localparam int unsigned ROW_W = $clog2(V_LINES) + 1;
    localparam int unsigned BIT_W = $clog2(WORD_W);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    state_t            state;
    state_t            stateNext;
    logic [COL_W-1:0]  col;
    logic [ROW_W-1:0]  row;
    logic [BIT_W-1:0]  bitCnt;
    logic [ADDR_W-1:0] wordIdx;
    // The oldest pixel of a word leaves through the pushed word, so only
    // WORD_W-1 pixels need holding.
    logic [WORD_W-2:0] shreg;

    logic              armStart;
    logic              accept;
    logic              wordDone;
    logic              lineEnd;
    logic              frameEnd;
    logic              pop;
    fifoEntry_t        pushEntry;
    fifoEntry_t        headEntry;
    logic              fifoFull;
    logic              fifoEmpty;
    logic [CNT_W-1:0]  fifoCount;

    assign armStart = (state == IDLE) && iSTART;
    assign accept   = (state == CAPTURE) && iPIXEL_VALID;
    assign wordDone = accept && (bitCnt == BIT_W'(WORD_W - 1));
    assign lineEnd  = accept && (col == COL_W'(H_PIXELS - 1));
    assign frameEnd = lineEnd && (row == ROW_W'(V_LINES - 1));
    assign pop      = oSRAM_WE && iSRAM_ACK;

    assign pushEntry.index = wordIdx;
    assign pushEntry.data  = {shreg, iPIXEL};

    word_fifo #(
        .WIDTH ($bits(fifoEntry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .iCLK     (iCLK),
        .iRST_n   (iRST_n),
        .push     (wordDone),
        .pushData (pushEntry),
        .pop      (pop),
        .headData (headEntry),
        .full     (fifoFull),
        .empty    (fifoEmpty),
        .count    (fifoCount)
    );

    always_comb begin
        stateNext = state;
        unique case (state)
            IDLE:    if (iSTART)    stateNext = CAPTURE;
            CAPTURE: if (frameEnd)  stateNext = DRAIN;
            DRAIN:   if (fifoEmpty) stateNext = DONE;
            DONE:                   stateNext = IDLE;
            default:                stateNext = IDLE;
        endcase
    end

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            state      <= IDLE;
            col        <= '0;
            row        <= '0;
            bitCnt     <= '0;
            wordIdx    <= '0;
            shreg      <= '0;
            oLINE_DONE <= 1'b0;
            oOVERFLOW  <= 1'b0;
        end else begin
            state      <= stateNext;
            oLINE_DONE <= lineEnd;
            if (armStart) begin
                col       <= '0;
                row       <= '0;
                bitCnt    <= '0;
                wordIdx   <= '0;
                oOVERFLOW <= 1'b0;
            end else if (accept) begin
                shreg  <= {shreg[WORD_W-3:0], iPIXEL};
                bitCnt <= wordDone ? '0 : bitCnt + 1'b1;
                if (lineEnd) begin
                    col <= '0;
                    row <= row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
                // Index advances even for a dropped word so later addresses stay right.
                if (wordDone) begin
                    wordIdx <= wordIdx + 1'b1;
                    if (fifoFull && !pop) begin
                        oOVERFLOW <= 1'b1;
                    end
                end
            end
        end
    end

    assign oSRAM_WE   = (fifoCount != '0);
    assign oSRAM_ADDR = oSRAM_WE ? ADDR_W'(BASE_ADDR + headEntry.index) : '0;
    assign oSRAM_DATA = oSRAM_WE ? headEntry.data : '0;
    assign oFinished  = (state == DONE);
    assign oBUSY      = (state == CAPTURE) || (state == DRAIN);

endmodule

// File: tb/tb_seri2para_frame_packer.sv
// Directed bench for seri2para_frame_packer on a reduced 64x6 frame, with a
// capacity-aware scoreboard of expected SRAM writes.
module tb_seri2para_frame_packer;
    localparam int unsigned H     = 64;
    localparam int unsigned V     = 6;
    localparam int unsigned WW    = 16;
    localparam int unsigned AW    = 20;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned WPF   = H * V / WW;
    localparam logic [AW-1:0] BASE = 20'h01000;

    logic          iCLK = 1'b0;
    logic          iRST_n = 1'b1;
    logic          iSTART = 1'b0;
    logic          iPIXEL = 1'b0;
    logic          iPIXEL_VALID = 1'b0;
    logic          iSRAM_ACK = 1'b0;
    logic          oSRAM_WE;
    logic [AW-1:0] oSRAM_ADDR;
    logic [WW-1:0] oSRAM_DATA;
    logic          oLINE_DONE;
    logic          oFinished;
    logic          oOVERFLOW;
    logic          oBUSY;

    seri2para_frame_packer #(
        .H_PIXELS   (H),
        .V_LINES    (V),
        .WORD_W     (WW),
        .ADDR_W     (AW),
        .BASE_ADDR  (BASE),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .iCLK         (iCLK),
        .iRST_n       (iRST_n),
        .iSTART       (iSTART),
        .iPIXEL       (iPIXEL),
        .iPIXEL_VALID (iPIXEL_VALID),
        .oSRAM_WE     (oSRAM_WE),
        .oSRAM_ADDR   (oSRAM_ADDR),
        .oSRAM_DATA   (oSRAM_DATA),
        .iSRAM_ACK    (iSRAM_ACK),
        .oLINE_DONE   (oLINE_DONE),
        .oFinished    (oFinished),
        .oOVERFLOW    (oOVERFLOW),
        .oBUSY        (oBUSY)
    );

    always #5 iCLK = ~iCLK;

    typedef struct {
        logic [AW-1:0] addr;
        logic [WW-1:0] data;
    } wr_t;

    wr_t           sbq[$];
    int            checks = 0;
    int            failures = 0;
    bit            mCap, mLine, mOvf, firstPending;
    int            pixIdx, mWord;
    logic [WW-1:0] mShreg;
    int            nWrites, nLines, nFinished, nDrops, cyc;
    int            pixMode, ackMode, stallFrom, stallLen, waitCnt, tail;
    logic [AW-1:0] firstAddr;
    logic [WW-1:0] firstData;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic pixVal(input int p, input int mode);
        logic [15:0] first;
        first = 16'hB001;
        if (mode == 0) return (p % 16) == 0;
        if (p < 16) return first[15-p];
        return ((p * 13 + p / 7) % 5) < 2;
    endfunction

    // One clock: called at a falling edge, drives inputs, checks, advances the model.
    task automatic step(input bit vld, input bit start);
        bit  ack, pix;
        wr_t e;
        case (ackMode)
            0:       ack = 1'b1;
            1:       ack = (waitCnt == 3);
            default: ack = !(cyc >= stallFrom && cyc < stallFrom + stallLen);
        endcase
        pix = (mCap && vld) ? pixVal(pixIdx, pixMode) : 1'($urandom_range(0, 1));
        iPIXEL = pix;
        iPIXEL_VALID = vld;
        iSTART = start;
        iSRAM_ACK = ack;
        #1;
        chk("we", oSRAM_WE, sbq.size() != 0);
        if (oSRAM_WE && sbq.size() != 0) begin
            chk("addr", oSRAM_ADDR, sbq[0].addr);
            chk("data", oSRAM_DATA, sbq[0].data);
        end
        chk("line_done", oLINE_DONE, mLine);
        chk("overflow", oOVERFLOW, mOvf);
        if (oLINE_DONE) nLines++;
        if (oFinished) nFinished++;
        if (oSRAM_WE && ack) begin
            nWrites++;
            if (firstPending) begin
                firstAddr = oSRAM_ADDR;
                firstData = oSRAM_DATA;
                firstPending = 0;
            end
        end
        if (oSRAM_WE) waitCnt = ack ? 0 : waitCnt + 1;
        if (ack && sbq.size() != 0) void'(sbq.pop_front());
        mLine = 0;
        if (start && !mCap) begin
            mCap = 1;
            pixIdx = 0;
            mWord = 0;
            mOvf = 0;
        end else if (mCap && vld) begin
            mShreg = {mShreg[WW-2:0], pix};
            if (pixIdx % H == H - 1) mLine = 1;
            if (pixIdx % WW == WW - 1) begin
                e.addr = BASE + AW'(mWord);
                e.data = mShreg;
                if (sbq.size() < DEPTH) sbq.push_back(e);
                else begin
                    mOvf = 1;
                    nDrops++;
                end
                mWord++;
            end
            pixIdx++;
            if (pixIdx == H * V) mCap = 0;
        end
        cyc++;
        @(negedge iCLK);
    endtask

    task automatic run_frame(input int pm, input int am, input int validPct, input int midStart,
                             input int stallOfs, input int stallCycles, output int tailCyc);
        int f0;
        pixMode = pm;
        ackMode = am;
        waitCnt = 0;
        stallFrom = cyc + stallOfs;
        stallLen = stallCycles;
        nWrites = 0;
        nLines = 0;
        nDrops = 0;
        firstPending = 1;
        f0 = nFinished;
        step(0, 1);
        chk("busy_after_start", oBUSY, 1);
        while (mCap) step($urandom_range(0, 99) < validPct, pixIdx == midStart);
        tailCyc = 0;
        while (nFinished == f0 && tailCyc < 2000) begin
            step(0, 0);
            tailCyc++;
        end
        step(0, 0);
        chk("finished_pulses", nFinished - f0, 1);
        chk("finished_low_after", oFinished, 0);
        chk("busy_low_after", oBUSY, 0);
        chk("words_accounted", nWrites + nDrops, WPF);
        chk("line_pulses", nLines, V);
        chk("sb_empty", sbq.size(), 0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_we"}, oSRAM_WE, 0);
        chk({tag, "_addr"}, oSRAM_ADDR, 0);
        chk({tag, "_data"}, oSRAM_DATA, 0);
        chk({tag, "_line"}, oLINE_DONE, 0);
        chk({tag, "_fin"}, oFinished, 0);
        chk({tag, "_ovf"}, oOVERFLOW, 0);
        chk({tag, "_busy"}, oBUSY, 0);
    endtask

    initial begin
        cyc = 0;
        nFinished = 0;
        ackMode = 0;
        mShreg = '0;
        #2 iRST_n = 1'b0;
        #1 chk_all_zero("reset");
        @(negedge iCLK);
        @(negedge iCLK);
        iRST_n = 1'b1;

        // Gap-free frame, ACK tied high: one 16'h8000 word per 16 pixels.
        run_frame(0, 0, 100, -1, 0, 0, tail);
        chk("finish_latency", tail, 3);

        // First word B001 at BASE, ACK delayed 3 cycles per word.
        run_frame(1, 1, 100, -1, 0, 0, tail);
        chk("first_addr", firstAddr, 20'h01000);
        chk("first_data", firstData, 16'hB001);

        // ACK stalled for 100 cycles mid-frame: drops, sticky overflow.
        run_frame(1, 2, 100, -1, 100, 100, tail);
        chk("ovf_sticky", oOVERFLOW, 1);

        // 50% valid with a stray iSTART mid-capture; new frame clears overflow.
        run_frame(1, 0, 50, 200, 0, 0, tail);
        chk("ovf_cleared", oOVERFLOW, 0);

        // Reset mid-frame with writes pending.
        pixMode = 0;
        ackMode = 2;
        stallFrom = cyc;
        stallLen = 100000;
        step(0, 1);
        repeat (70) step(1, 0);
        chk("we_pending_pre_reset", oSRAM_WE, 1);
        iRST_n = 1'b0;
        #1 chk_all_zero("midreset");
        sbq.delete();
        mCap = 0;
        mLine = 0;
        mOvf = 0;
        @(negedge iCLK);
        iRST_n = 1'b1;
        stallLen = 0;
        run_frame(0, 0, 100, -1, 0, 0, tail);
        chk("post_reset_first_addr", firstAddr, BASE);
        chk("post_reset_first_data", firstData, 16'h8000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
